// File: rtl/matrix_subtractor_seq_if.sv
// Stream bundle for the element-serial 3x3 matrix subtractor.
// The slave modport is the subtractor's view; master is the producer/consumer side.
interface matrix_subtractor_seq_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_diff;
    logic [3:0]   out_idx;
    logic         out_borrow;
    logic         out_last;
    logic         mat_done;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_diff, out_idx, out_borrow, out_last, mat_done
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_diff, out_idx, out_borrow, out_last, mat_done
    );
endinterface

// File: rtl/matrix_subtractor_seq.sv
// Element-serial 3x3 matrix subtractor D = A - B.
// Loads nine (a,b) pairs, buffers the differences, then drains D row-major.
// Optional macro SUB_SAT_EN: underflowing elements are stored as 0 instead of wrapping.
//
// state   | meaning
// --------+--------------------------------------------------
// S_LOAD  | accepting input pairs, wr_idx_q counts 0..8
// S_DRAIN | presenting buffered D[rd_idx_q] downstream, 0..8
module matrix_subtractor_seq #(
    parameter int W = 16,
    parameter int N = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_subtractor_seq_if.slave  bus
);
    localparam logic [0:0] S_LOAD   = 1'b0;
    localparam logic [0:0] S_DRAIN  = 1'b1;
    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    logic [0:0]   state_q, state_d;
    logic [3:0]   wr_idx_q, wr_idx_d;
    logic [3:0]   rd_idx_q, rd_idx_d;
    logic [W-1:0] diff_q [N];
    logic [N-1:0] brw_q;

    logic         in_fire;
    logic         drain;
    logic         under;
    logic [W-1:0] raw_diff;
    logic [W-1:0] wr_data;

    assign drain    = (state_q == S_DRAIN);
    assign in_fire  = (state_q == S_LOAD) && bus.in_valid && (wr_idx_q <= LAST_IDX);
    assign under    = (bus.in_a < bus.in_b);
    assign raw_diff = bus.in_a - bus.in_b;

`ifdef SUB_SAT_EN
    assign wr_data = under ? '0 : raw_diff;
`else
    assign wr_data = raw_diff;
`endif

    // Next-state and index advance; out-of-range indices are pulled back to 0.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            S_LOAD: begin
                if (wr_idx_q > LAST_IDX) begin
                    wr_idx_d = '0;
                end else if (in_fire) begin
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        wr_idx_d = wr_idx_q + 4'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (rd_idx_q > LAST_IDX) begin
                    rd_idx_d = '0;
                end else if (bus.out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = S_LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d  = S_LOAD;
                wr_idx_d = '0;
                rd_idx_d = '0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Difference/borrow buffer; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (rst_n && in_fire) begin
            diff_q[wr_idx_q] <= wr_data;
            brw_q[wr_idx_q]  <= under;
        end
    end

    assign bus.in_ready   = (state_q == S_LOAD);
    assign bus.out_valid  = drain;
    assign bus.out_idx    = rd_idx_q;
    assign bus.out_diff   = drain ? diff_q[rd_idx_q] : '0;
    assign bus.out_borrow = drain & brw_q[rd_idx_q];
    assign bus.out_last   = drain && (rd_idx_q == LAST_IDX);
    assign bus.mat_done   = drain && (rd_idx_q == LAST_IDX) && bus.out_ready;
endmodule

// File: tb/tb_matrix_subtractor_seq.sv
// Randomized bench for matrix_subtractor_seq with a per-cycle behavioural model
// and directed literal checks for reset, basic, underflow, backpressure, gaps and abort.
module tb_matrix_subtractor_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_subtractor_seq_if #(.W(W)) bus();
    matrix_subtractor_seq #(.W(W), .N(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [15:0] d;
        logic        b;
        logic [3:0]  i;
        logic        l;
        logic        md;
    } obs_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] feed[$];
    obs_t        obs[$];
    int          gap_pct  = 0;
    int          out_mode = 0;
    bit          hold     = 1'b0;

    // model state: matrix being loaded, then drained
    logic [15:0] ea[9];
    logic        eb[9];
    int          loaded = 0;
    int          drained = 0;
    int          in_cnt = 0;
    int          md_cnt = 0;
    int          ncyc = 0;
    int          first_in = -1;
    int          md_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // stimulus driver: presents feed head with random gaps, shapes out_ready
    initial begin
        bit xi;
        int cyc;
        cyc = 0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            xi = bus.in_valid && bus.in_ready && rst_n;
            @(posedge clk);
            #1;
            if (xi && feed.size() > 0) void'(feed.pop_front());
            cyc++;
            if (!hold && feed.size() > 0 && $urandom_range(99) >= 32'(gap_pct)) begin
                bus.in_valid = 1'b1;
                bus.in_a = feed[0][31:16];
                bus.in_b = feed[0][15:0];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_a = 16'($urandom);
                bus.in_b = 16'($urandom);
            end
            case (out_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(1));
                default: bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
        end
    end

    // behavioural model and per-cycle compare
    initial begin
        bit          draining;
        logic [15:0] d;
        logic        b;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                loaded = 0;
                drained = 0;
            end else begin
                draining = (loaded == 9);
                chk("in_ready", 32'(bus.in_ready), 32'(!draining));
                chk("out_valid", 32'(bus.out_valid), 32'(draining));
                if (draining) begin
                    chk("out_diff", 32'(bus.out_diff), 32'(ea[drained]));
                    chk("out_borrow", 32'(bus.out_borrow), 32'(eb[drained]));
                    chk("out_idx", 32'(bus.out_idx), 32'(drained));
                    chk("out_last", 32'(bus.out_last), 32'(drained == 8));
                    chk("mat_done", 32'(bus.mat_done), 32'(bus.out_ready && drained == 8));
                end else begin
                    chk("idle_diff", 32'(bus.out_diff), 32'h0);
                    chk("idle_borrow", 32'(bus.out_borrow), 32'h0);
                    chk("idle_idx", 32'(bus.out_idx), 32'h0);
                    chk("idle_last", 32'(bus.out_last), 32'h0);
                    chk("idle_done", 32'(bus.mat_done), 32'h0);
                end
                if (!draining && bus.in_valid === 1'b1) begin
                    d = bus.in_a - bus.in_b;
                    b = (bus.in_a < bus.in_b);
`ifdef SUB_SAT_EN
                    if (b) d = 16'h0;
`endif
                    ea[loaded] = d;
                    eb[loaded] = b;
                    loaded++;
                    in_cnt++;
                    if (first_in < 0) first_in = ncyc;
                end else if (draining && bus.out_ready === 1'b1) begin
                    obs.push_back('{d: bus.out_diff, b: bus.out_borrow, i: bus.out_idx,
                                    l: bus.out_last, md: bus.mat_done});
                    if (bus.mat_done === 1'b1) begin
                        md_cnt++;
                        md_cyc = ncyc;
                    end
                    drained++;
                    if (drained == 9) begin
                        loaded = 0;
                        drained = 0;
                    end
                end
            end
        end
    end

    task automatic wait_obs(input int n, input string nm);
        int t;
        t = 0;
        while (obs.size() < n && t < n * 40 + 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk(nm, 32'(obs.size()), 32'(n));
    endtask

    task automatic push_rand_matrix();
        for (int k = 0; k < 9; k++) feed.push_back($urandom);
    endtask

    initial begin
        int md0;
        int base;
        int t;
        // 1: reset held two cycles
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_mat_done", 32'(bus.mat_done), 32'h0);

        // 2: basic A=100+k, B=k, full throughput
        @(posedge clk);
        #2;
        obs.delete();
        first_in = -1;
        out_mode = 0;
        gap_pct = 0;
        for (int k = 0; k < 9; k++) feed.push_back({16'(100 + k), 16'(k)});
        wait_obs(9, "basic_count");
        for (int k = 0; k < 9 && k < obs.size(); k++) begin
            chk("basic_diff", 32'(obs[k].d), 32'd100);
            chk("basic_borrow", 32'(obs[k].b), 32'h0);
            chk("basic_idx", 32'(obs[k].i), 32'(k));
            chk("basic_last", 32'(obs[k].l), 32'(k == 8));
            chk("basic_done", 32'(obs[k].md), 32'(k == 8));
        end
        chk("basic_cycles", 32'(md_cyc - first_in + 1), 32'd18);
        chk("basic_done_cnt", 32'(md_cnt), 32'd1);

        // 3: underflow at element 3
        repeat (3) @(posedge clk);
        #2;
        obs.delete();
        for (int k = 0; k < 9; k++)
            feed.push_back((k == 3) ? {16'h0001, 16'h0002} : {16'(k + 5), 16'(k)});
        wait_obs(9, "under_count");
        if (obs.size() > 3) begin
`ifdef SUB_SAT_EN
            chk("under_diff", 32'(obs[3].d), 32'h0000);
`else
            chk("under_diff", 32'(obs[3].d), 32'hFFFF);
`endif
            chk("under_borrow", 32'(obs[3].b), 32'h1);
            chk("under_next", 32'(obs[4].d), 32'd5);
        end

        // 4: backpressure 1,0,0,1 during drain
        repeat (3) @(posedge clk);
        #2;
        obs.delete();
        out_mode = 2;
        push_rand_matrix();
        wait_obs(9, "bp_count");
        for (int k = 0; k < obs.size(); k++) chk("bp_order", 32'(obs[k].i), 32'(k));
        out_mode = 0;

        // 5: random input gaps and random out_ready over several matrices
        repeat (3) @(posedge clk);
        #2;
        obs.delete();
        gap_pct = 50;
        out_mode = 1;
        repeat (6) push_rand_matrix();
        wait_obs(54, "gap_count");
        for (int k = 0; k < obs.size(); k++) chk("gap_order", 32'(obs[k].i), 32'(k % 9));
        gap_pct = 0;
        out_mode = 0;

        // 6: reset after 5 inputs, then A=B=0x1234
        repeat (20) @(posedge clk);
        #2;
        md0 = md_cnt;
        base = in_cnt;
        push_rand_matrix();
        t = 0;
        while (in_cnt < base + 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("abort_inputs", 32'(in_cnt >= base + 5), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        hold = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        feed.delete();
        obs.delete();
        rst_n = 1'b1;
        hold = 1'b0;
        chk("abort_no_done", 32'(md_cnt), 32'(md0));
        for (int k = 0; k < 9; k++) feed.push_back({16'h1234, 16'h1234});
        wait_obs(9, "abort_count");
        for (int k = 0; k < obs.size(); k++) begin
            chk("abort_diff", 32'(obs[k].d), 32'h0);
            chk("abort_borrow", 32'(obs[k].b), 32'h0);
            chk("abort_idx", 32'(obs[k].i), 32'(k));
        end
        chk("abort_done_cnt", 32'(md_cnt), 32'(md0 + 1));

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
